// File: rtl/floo_credit_tx_pkg.sv
// Shared helpers for the credit-based link transmitter: decoding of the
// per-cycle counter operation from the take/return pair.
package floo_credit_tx_pkg;

  typedef enum logic [1:0] {
    CntHold   = 2'b00,
    CntReturn = 2'b01,
    CntTake   = 2'b10,
    CntBoth   = 2'b11
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic take, input logic credit);
    return cnt_op_e'({take, credit});
  endfunction

endpackage

// File: rtl/floo_credit_tx.sv
// Credit-based link transmitter: turns a router valid/ready output into a valid-only link whose
// flow control is a credit counter refilled by single-cycle credit pulses from the receiver.
module floo_credit_tx
  import floo_credit_tx_pkg::*;
#(
  parameter int unsigned NumCredits = 4,
  parameter bit          OutReg     = 1'b1,
  parameter type         flit_t     = logic,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  flit_t               data_i,
  output logic                valid_o,
  output flit_t               data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                take;

  // ready_o comes from the counter alone; the reset gate only stops flits that would be
  // dropped anyway from appearing on a pass-through link.
  assign ready_o = (cnt_q != '0);
  assign take    = valid_i && ready_o && !rst_i;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (cnt_op(take, credit_i))
      CntTake: cnt_d = cnt_q - CntOne;
      CntReturn: begin
        // A return with every credit already home means the receiver is out of sync.
        if (cnt_q == MaxCnt) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= MaxCnt;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  if (OutReg) begin : gen_out_reg
    logic  out_valid_q;
    flit_t out_data_q, out_data_d;

    always_comb begin
      out_data_d = out_data_q;
      if (take) begin
        out_data_d = data_i;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= take;
        out_data_q  <= out_data_d;
      end
    end

    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
  end else begin : gen_out_comb
    assign valid_o = take;
    assign data_o  = data_i;
  end

  assign credits_o = cnt_q;
  assign err_o     = err_q;
  assign idle_o    = (cnt_q == MaxCnt) && !valid_o;

endmodule

// File: tb/tb_floo_credit_tx.sv
// Directed bench for floo_credit_tx: a registered and a pass-through instance share stimulus.
module tb_floo_credit_tx;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] data_in;
  logic       credit_in;

  logic       r_ready, r_valid, r_idle, r_err;
  logic [7:0] r_data;
  logic [2:0] r_credits;
  logic       c_ready, c_valid, c_idle, c_err;
  logic [7:0] c_data;
  logic [2:0] c_credits;

  int n_checks = 0;
  int n_fail   = 0;

  floo_credit_tx #(
    .NumCredits(4),
    .OutReg    (1'b1),
    .flit_t    (logic [7:0])
  ) u_dut_reg (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_in),
    .ready_o  (r_ready),
    .data_i   (data_in),
    .valid_o  (r_valid),
    .data_o   (r_data),
    .credit_i (credit_in),
    .credits_o(r_credits),
    .idle_o   (r_idle),
    .err_o    (r_err)
  );

  floo_credit_tx #(
    .NumCredits(4),
    .OutReg    (1'b0),
    .flit_t    (logic [7:0])
  ) u_dut_comb (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid_in),
    .ready_o  (c_ready),
    .data_i   (data_in),
    .valid_o  (c_valid),
    .data_o   (c_data),
    .credit_i (credit_in),
    .credits_o(c_credits),
    .idle_o   (c_idle),
    .err_o    (c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = 8'h0;
    credit_in = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      cyc();
      valid_in  = 1'($urandom);
      credit_in = 1'($urandom);
      data_in   = 8'($urandom);
      @(negedge clk);
      check_val("rst_valid", {31'd0, r_valid}, 32'd0);
      check_val("rst_ready", {31'd0, r_ready}, 32'd1);
      check_val("rst_credits", {29'd0, r_credits}, 32'd4);
      check_val("rst_idle", {31'd0, r_idle}, 32'd1);
      check_val("rst_err", {31'd0, r_err}, 32'd0);
      check_val("rst_c_valid", {31'd0, c_valid}, 32'd0);
    end
    cyc();
    rst       = 1'b0;
    valid_in  = 1'b0;
    credit_in = 1'b0;
    data_in   = 8'h0;

    // Drain: 6 cycles of traffic, only 4 credits
    for (int i = 1; i <= 6; i++) begin
      cyc();
      valid_in = 1'b1;
      data_in  = 8'(i);
      @(negedge clk);
      k = (5 - i > 0) ? 5 - i : 0;
      check_val("drain_credits", {29'd0, r_credits}, 32'(k));
      check_val("drain_ready", {31'd0, r_ready}, (i <= 4) ? 32'd1 : 32'd0);
      check_val("drain_r_valid", {31'd0, r_valid}, (i >= 2 && i <= 5) ? 32'd1 : 32'd0);
      if (i == 1) check_val("drain_r_data0", {24'd0, r_data}, 32'd0);
      else if (i <= 5) check_val("drain_r_data", {24'd0, r_data}, 32'(i - 1));
      else check_val("drain_r_hold", {24'd0, r_data}, 32'd4);
      check_val("drain_c_valid", {31'd0, c_valid}, (i <= 4) ? 32'd1 : 32'd0);
      check_val("drain_c_data", {24'd0, c_data}, 32'(i));
    end

    // Return one credit while 0x5 waits at the input
    cyc();
    data_in   = 8'h5;
    credit_in = 1'b1;
    @(negedge clk);
    check_val("ret_ready_pre", {31'd0, r_ready}, 32'd0);
    check_val("ret_c_valid_pre", {31'd0, c_valid}, 32'd0);
    cyc();
    credit_in = 1'b0;
    @(negedge clk);
    check_val("ret_ready", {31'd0, r_ready}, 32'd1);
    check_val("ret_credits", {29'd0, r_credits}, 32'd1);
    check_val("ret_c_valid", {31'd0, c_valid}, 32'd1);
    check_val("ret_c_data", {24'd0, c_data}, 32'h5);
    cyc();
    valid_in = 1'b0;
    @(negedge clk);
    check_val("ret_credits_post", {29'd0, r_credits}, 32'd0);
    check_val("ret_r_valid", {31'd0, r_valid}, 32'd1);
    check_val("ret_r_data", {24'd0, r_data}, 32'h5);
    check_val("ret_ready_post", {31'd0, r_ready}, 32'd0);

    // Simultaneous take and return at cnt == 1
    cyc();
    credit_in = 1'b1;
    cyc();
    credit_in = 1'b0;
    @(negedge clk);
    check_val("sim_credits_pre", {29'd0, r_credits}, 32'd1);
    cyc();
    valid_in  = 1'b1;
    data_in   = 8'h7;
    credit_in = 1'b1;
    cyc();
    valid_in  = 1'b0;
    credit_in = 1'b0;
    @(negedge clk);
    check_val("sim_credits", {29'd0, r_credits}, 32'd1);
    check_val("sim_ready", {31'd0, r_ready}, 32'd1);
    check_val("sim_r_valid", {31'd0, r_valid}, 32'd1);
    check_val("sim_r_data", {24'd0, r_data}, 32'h7);

    // Refill to 4, then overflow
    cyc();
    credit_in = 1'b1;
    cyc();
    cyc();
    cyc();
    credit_in = 1'b0;
    @(negedge clk);
    check_val("full_credits", {29'd0, r_credits}, 32'd4);
    check_val("full_err", {31'd0, r_err}, 32'd0);
    check_val("full_idle", {31'd0, r_idle}, 32'd1);
    cyc();
    credit_in = 1'b1;
    cyc();
    credit_in = 1'b0;
    @(negedge clk);
    check_val("ovf_credits", {29'd0, r_credits}, 32'd4);
    check_val("ovf_err", {31'd0, r_err}, 32'd1);
    check_val("ovf_c_err", {31'd0, c_err}, 32'd1);
    cyc();
    valid_in = 1'b1;
    data_in  = 8'h8;
    cyc();
    valid_in = 1'b0;
    @(negedge clk);
    check_val("busy_credits", {29'd0, r_credits}, 32'd3);
    check_val("busy_idle", {31'd0, r_idle}, 32'd0);
    check_val("busy_r_data", {24'd0, r_data}, 32'h8);
    check_val("sticky_err", {31'd0, r_err}, 32'd1);
    cyc();
    credit_in = 1'b1;
    cyc();
    credit_in = 1'b0;
    @(negedge clk);
    check_val("sticky_err2", {31'd0, r_err}, 32'd1);
    check_val("back_idle", {31'd0, r_idle}, 32'd1);
    check_val("back_c_idle", {31'd0, c_idle}, 32'd1);

    // Mid-burst asynchronous reset
    cyc();
    valid_in = 1'b1;
    data_in  = 8'h9;
    cyc();
    data_in = 8'hA;
    @(negedge clk);
    check_val("mid_credits", {29'd0, r_credits}, 32'd3);
    check_val("mid_r_valid", {31'd0, r_valid}, 32'd1);
    check_val("mid_c_valid", {31'd0, c_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_c_credits", {29'd0, c_credits}, 32'd4);
    check_val("arst_c_valid", {31'd0, c_valid}, 32'd0);
    check_val("arst_r_credits", {29'd0, r_credits}, 32'd4);
    check_val("arst_r_valid", {31'd0, r_valid}, 32'd0);
    check_val("arst_r_data", {24'd0, r_data}, 32'd0);
    check_val("arst_err", {31'd0, r_err}, 32'd0);
    valid_in = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
